// File: rtl/game_pkg.sv
// Shared definitions for the reflex game: state encoding, round-end time and LFSR taps.
package game_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StArm,
        StShow,
        StHit,
        StGap,
        StDone
    } state_t;

    localparam logic [5:0]  END_TIME  = 6'd31;
    // Fibonacci taps 16,14,13,11 expressed as bit positions 15,13,12,10.
    localparam logic [15:0] LFSR_TAPS = 16'hB400;

    // Never repeat the previous target back to back.
    function automatic logic [3:0] next_target(input logic [3:0] cand, input logic [3:0] prev);
        return (cand == prev) ? cand + 4'd1 : cand;
    endfunction

endpackage

// File: rtl/lfsr16.sv
// 16-bit Fibonacci LFSR shifting left, feedback into bit 0.
module lfsr16
    import game_pkg::*;
#(
    parameter logic [15:0] SEED = 16'hACE1
) (
    input  logic        clk_2,
    input  logic        rst,
    input  logic        en,
    output logic [15:0] q
);

    logic [15:0] q_q;

    always_ff @(posedge clk_2) begin
        if (rst) begin
            q_q <= SEED;
        end else if (en) begin
            q_q <= {q_q[14:0], ^(q_q & LFSR_TAPS)};
        end
    end

    assign q = q_q;

endmodule

// File: rtl/target_hit_gen.sv
// Lights a pseudo-random target LED and reports correct hits (keepFinale) or misses.
module target_hit_gen #(
    parameter int unsigned TARGET_TICKS = 100,
    parameter int unsigned GAP_TICKS    = 20,
    parameter logic [5:0]  END_TIME     = game_pkg::END_TIME,
    parameter logic [15:0] SEED         = 16'hACE1
) (
    input  logic        clk_2,
    input  logic        rst,
    input  logic        start,
    input  logic [5:0]  timerIn,
    input  logic [15:0] sw,
    output logic [15:0] led,
    output logic        keepFinale,
    output logic        miss,
    output logic [3:0]  target
);

    import game_pkg::*;

    localparam int unsigned CNT_MAX = (TARGET_TICKS > GAP_TICKS) ? TARGET_TICKS : GAP_TICKS;
    localparam int unsigned CW      = $clog2(CNT_MAX + 1);
    localparam logic [CW-1:0] TGT_LAST = CW'(TARGET_TICKS - 1);
    localparam logic [CW-1:0] GAP_LAST = CW'(GAP_TICKS - 1);

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [3:0]    target_q, target_d;
    logic [15:0]   led_q, led_d;
    logic          keep_q, keep_d;
    logic          miss_q, miss_d;
    logic [15:0]   sw_q;
    logic [15:0]   lfsr;
    logic [15:0]   rise;
    logic [15:0]   tgt_mask;
    logic [3:0]    cand;
    logic          wrong;
    logic          lfsr_unused;

    lfsr16 #(
        .SEED(SEED)
    ) u_lfsr (
        .clk_2(clk_2),
        .rst  (rst),
        .en   (1'b1),
        .q    (lfsr)
    );

    assign lfsr_unused = ^lfsr[15:4];
    assign rise        = sw & ~sw_q;
    assign tgt_mask    = 16'd1 << target_q;
    assign wrong       = |(rise & ~tgt_mask);
    assign cand        = next_target(lfsr[3:0], target_q);

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        target_d = target_q;
        led_d    = led_q;
        keep_d   = 1'b0;
        miss_d   = 1'b0;
        case (state_q)
            StIdle: begin
                led_d = '0;
                if (start) state_d = StArm;
            end
            StArm: begin
                target_d = cand;
                led_d    = 16'd1 << cand;
                cnt_d    = '0;
                state_d  = StShow;
            end
            StShow: begin
                cnt_d = cnt_q + 1'b1;
                // A wrong edge outranks a simultaneous correct one.
                if (wrong || (cnt_q == TGT_LAST && !(|(rise & tgt_mask)))) begin
                    miss_d  = 1'b1;
                    led_d   = '0;
                    cnt_d   = '0;
                    state_d = StGap;
                end else if (|(rise & tgt_mask)) begin
                    led_d   = '0;
                    cnt_d   = '0;
                    state_d = StHit;
                end
            end
            StHit: begin
                keep_d  = 1'b1;
                led_d   = '0;
                cnt_d   = '0;
                state_d = StGap;
            end
            StGap: begin
                led_d = '0;
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == GAP_LAST) begin
                    cnt_d   = '0;
                    state_d = StArm;
                end
            end
            StDone: begin
                led_d = '0;
                if (start) state_d = StArm;
            end
            default: state_d = StIdle;
        endcase
        // Round end overrides everything, including a pending hit pulse.
        if (state_q != StIdle && timerIn == END_TIME) begin
            state_d = StDone;
            led_d   = '0;
            keep_d  = 1'b0;
            miss_d  = 1'b0;
            cnt_d   = '0;
        end
    end

    always_ff @(posedge clk_2) begin
        if (rst) begin
            state_q  <= StIdle;
            cnt_q    <= '0;
            target_q <= '0;
            led_q    <= '0;
            keep_q   <= 1'b0;
            miss_q   <= 1'b0;
            sw_q     <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            target_q <= target_d;
            led_q    <= led_d;
            keep_q   <= keep_d;
            miss_q   <= miss_d;
            sw_q     <= sw;
        end
    end

    assign led        = led_q;
    assign keepFinale = keep_q;
    assign miss       = miss_q;
    assign target     = target_q;

endmodule

// File: tb/tb_target_hit_gen.sv
// Scoreboard bench for target_hit_gen: stimulus queues expected pulses, a monitor checks them.
module tb_target_hit_gen;

    localparam int TT = 100;
    localparam int GT = 20;

    logic        clk_2 = 1'b0;
    logic        rst;
    logic        start;
    logic [5:0]  timerIn;
    logic [15:0] sw;
    logic [15:0] led;
    logic        keepFinale;
    logic        miss;
    logic [3:0]  target;

    always #5 clk_2 = ~clk_2;

    target_hit_gen #(
        .TARGET_TICKS(TT),
        .GAP_TICKS   (GT),
        .END_TIME    (6'd31),
        .SEED        (16'hACE1)
    ) dut (
        .clk_2     (clk_2),
        .rst       (rst),
        .start     (start),
        .timerIn   (timerIn),
        .sw        (sw),
        .led       (led),
        .keepFinale(keepFinale),
        .miss      (miss),
        .target    (target)
    );

    typedef struct {
        bit is_hit;
        int at;
    } exp_t;

    exp_t        sb[$];
    exp_t        got_e;
    int          checks   = 0;
    int          failures = 0;
    int          cyc      = 0;
    int          c, s, d;
    bit          found;
    logic [15:0] m;
    logic [15:0] nx;
    logic [3:0]  prev;
    logic [3:0]  t;

    function automatic logic [15:0] lfsr_step(input logic [15:0] v);
        return {v[14:0], v[15] ^ v[13] ^ v[12] ^ v[10]};
    endfunction

    function automatic logic [3:0] pick(input logic [3:0] cv, input logic [3:0] p);
        return (cv == p) ? cv + 4'd1 : cv;
    endfunction

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got=%0h expected=%0h (cyc %0d)", name, got, exp, cyc);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk_2);
    endtask

    // Reference LFSR and cycle counter.
    always @(posedge clk_2) begin
        cyc <= cyc + 1;
        m   <= rst ? 16'hACE1 : lfsr_step(m);
    end

    // Monitor: every pulse must match the head of the scoreboard.
    always @(negedge clk_2) begin
        if (keepFinale === 1'b1 || miss === 1'b1) begin
            check("pulse_exclusive", 32'(keepFinale & miss), 32'd0);
            if (sb.size() == 0) begin
                check("unexpected_pulse", {30'd0, keepFinale, miss}, 32'd0);
            end else begin
                got_e = sb.pop_front();
                check("pulse_kind", {30'd0, keepFinale, miss}, got_e.is_hit ? 32'd2 : 32'd1);
                check("pulse_cycle", cyc, got_e.at);
            end
        end
    end

    // Called at the negedge just before ARM; predicts and verifies the next target.
    task automatic expect_show(input int arm, input bit hold, output logic [3:0] tn);
        logic [15:0] v;
        while (cyc < arm - 1) @(negedge clk_2);
        v  = lfsr_step(m);
        tn = pick(v[3:0], prev);
        if (hold) sw = 16'd1 << tn;
        tick(1);
        start = 1'b0;
        check("arm_led_dark", led, 32'd0);
        tick(1);
        check("show_target", target, tn);
        check("show_led", led, 32'(16'd1 << tn));
        check("target_differs", 32'(target == prev), 32'd0);
        prev = tn;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; start = 1'b0; timerIn = 6'd0; sw = 16'd0; prev = 4'd0;
        tick(3);
        check("rst_led", led, 32'd0);
        check("rst_target", target, 32'd0);
        check("rst_keep", keepFinale, 32'd0);
        check("rst_miss", miss, 32'd0);
        rst = 1'b0;
        tick(3);
        check("idle_led", led, 32'd0);

        // Correct hit on target 5.
        found = 1'b0;
        for (int i = 0; i < 4000 && !found; i++) begin
            nx = lfsr_step(m);
            if (pick(nx[3:0], prev) == 4'd5) found = 1'b1;
            else tick(1);
        end
        check("found_target5", 32'(found), 32'd1);
        start = 1'b1;
        expect_show(cyc + 1, 1'b0, t);
        check("target_is_5", target, 32'd5);
        c = cyc; sw = 16'd1 << t; sb.push_back('{1'b1, c + 2});
        tick(1); check("hit_led_off", led, 32'd0);
        tick(1); sw = 16'd0;
        expect_show(c + 2 + GT, 1'b0, t);

        // Wrong switch together with the correct one.
        c = cyc; sw = (16'd1 << t) | (16'd1 << (t + 4'd1)); sb.push_back('{1'b0, c + 1});
        tick(1); check("wrong_led_off", led, 32'd0); sw = 16'd0;
        expect_show(c + 1 + GT, 1'b0, t);

        // Timeout; next target's switch is held high before ARM.
        s = cyc; sb.push_back('{1'b0, s + TT});
        tick(TT - 1); check("timeout_led_on", led, 32'(16'd1 << t));
        tick(1); check("timeout_led_off", led, 32'd0);
        expect_show(s + TT + GT, 1'b1, t);

        // Held switch: no hit until released and pressed again.
        tick(5); check("held_no_hit", led, 32'(16'd1 << t));
        sw = 16'd0; tick(1);
        d = cyc; sw = 16'd1 << t; sb.push_back('{1'b1, d + 2});
        tick(1); check("held_hit_led_off", led, 32'd0);
        tick(1); sw = 16'd0;
        expect_show(d + 2 + GT, 1'b0, t);

        // Round end with a simultaneous correct edge.
        c = cyc; sw = 16'd1 << t; timerIn = 6'd31;
        tick(1); timerIn = 6'd0; sw = 16'd0;
        check("end_led_off", led, 32'd0);
        check("end_no_miss", miss, 32'd0);
        tick(1); check("end_keep_suppressed", keepFinale, 32'd0);
        tick(GT + 5); check("done_stays_dark", led, 32'd0);
        start = 1'b1;
        expect_show(cyc + 1, 1'b0, t);

        // Reset while in HIT.
        sw = 16'd1 << t;
        tick(1); rst = 1'b1; sw = 16'd0;
        tick(1); rst = 1'b0;
        check("rst_mid_keep", keepFinale, 32'd0);
        check("rst_mid_led", led, 32'd0);
        check("rst_mid_target", target, 32'd0);
        check("rst_mid_miss", miss, 32'd0);
        prev = 4'd0;
        // Seed ACE1 steps to 59C3, so the first target after reset is 3.
        start = 1'b1;
        expect_show(cyc + 1, 1'b0, t);
        check("restart_target", target, 32'd3);
        check("restart_led", led, 32'h0008);

        tick(5);
        check("scoreboard_empty", sb.size(), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
